// File: rtl/axis_pkg.sv
// Shared stream types for the window-function path: the integer complex sample,
// the window controller state and the sign-extension helper used by the multiplier.
package axis_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } sample_t_int;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } wfunc_ctrl_state_t;

  function automatic logic signed [2*SAMPLE_W-1:0] sext(input logic signed [SAMPLE_W-1:0] x);
    return {{SAMPLE_W{x[SAMPLE_W-1]}}, x};
  endfunction

endpackage

// File: rtl/complex_int_mult.sv
// Pipelined complex integer multiplier: z = a * b, kept to SAMPLE_W bits per part
// (two's-complement wrap), PIPE_NUM register stages that advance only when en is high.
module complex_int_mult
  import axis_pkg::*;
#(
  parameter int PIPE_NUM = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  sample_t_int a,
  input  sample_t_int b,
  output sample_t_int z
);

  logic signed [2*SAMPLE_W-1:0] rr, ii, ri, ir, re_sum, im_sum;
  sample_t_int prod;
  sample_t_int pipe [PIPE_NUM];

  assign rr     = sext(a.re) * sext(b.re);
  assign ii     = sext(a.im) * sext(b.im);
  assign ri     = sext(a.re) * sext(b.im);
  assign ir     = sext(a.im) * sext(b.re);
  assign re_sum = rr - ii;
  assign im_sum = ri + ir;

  // Low bits are exact modulo 2^SAMPLE_W, so wrapping here needs no extra logic.
  assign prod.re = re_sum[SAMPLE_W-1:0];
  assign prod.im = im_sum[SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_NUM; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= prod;
      for (int i = 1; i < PIPE_NUM; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign z = pipe[PIPE_NUM-1];

endmodule

// File: rtl/wfunc_mult_ctrl.sv
// Window-function sequencer: feeds samples and coefficients into the multiplier,
// shadows valid/last through its pipeline and resynchronises on framing errors.
module wfunc_mult_ctrl
  import axis_pkg::*;
#(
  parameter int PIPE_NUM  = 10,
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  sample_t_int       s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [ADDR_W-1:0] coef_addr,
  input  sample_t_int       coef_data,
  output sample_t_int       m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output wfunc_ctrl_state_t state_dbg
);

  // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
  // valid never waits on ready, and data/last are held while valid is high and ready is low.

  wfunc_ctrl_state_t state;
  logic [ADDR_W-1:0] idx;
  logic [PIPE_NUM-1:0] vld, lst;
  logic adv, accept, idx_end, run;

  assign run     = (state == RUN);
  assign adv     = ~vld[PIPE_NUM-1] | m_axis_tready;
  assign s_axis_tready = ~run | adv;
  assign accept  = s_axis_tvalid & s_axis_tready;
  assign idx_end = (idx == ADDR_W'(FRAME_LEN - 1));

  assign coef_addr     = idx;
  assign m_axis_tvalid = vld[PIPE_NUM-1];
  assign m_axis_tlast  = lst[PIPE_NUM-1];
  assign state_dbg     = state;

  complex_int_mult #(.PIPE_NUM(PIPE_NUM)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .a     (s_axis_tdata),
    .b     (coef_data),
    .z     (m_axis_tdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      idx       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            if (s_axis_tlast || idx_end) idx <= '0;
            else                          idx <= idx + 1'b1;
            if (s_axis_tlast && !idx_end) frame_err <= 1'b1;
            // Frame overran without tlast: drop input until the source's own tlast.
            if (!s_axis_tlast && idx_end) begin
              frame_err <= 1'b1;
              state     <= SYNC;
            end
          end
        end
        SYNC: begin
          idx <= '0;
          if (accept && s_axis_tlast) state <= RUN;
        end
        default: begin
          state <= RUN;
          idx   <= '0;
        end
      endcase
    end
  end

  // Shadow valid/last move in lock-step with the multiplier stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      lst <= '0;
    end else if (adv) begin
      vld[0] <= run & accept;
      lst[0] <= run & accept & (s_axis_tlast | idx_end);
      for (int i = 1; i < PIPE_NUM; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: doc/wfunc_mult_ctrl.md
# wfunc_mult_ctrl

Sequencing controller that applies a complex window coefficient to a framed AXI-Stream of complex samples. It owns one `complex_int_mult` instance and drives its enable, operands and coefficient index. It tracks valid/last through the multiplier pipeline and stalls the whole pipe on downstream backpressure. It sits between the sample source and the FFT input in the window-function path.

## Interface
- `PIPE_NUM`, 10, latency of the internal multiplier in enabled cycles (≥1)
- `FRAME_LEN`, 1024, samples per frame (≥2)
- `ADDR_W`, `$clog2(FRAME_LEN)`, coefficient index width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `s_axis_tdata` in `sample_t_int`: input sample
- `s_axis_tvalid` in 1: input valid
- `s_axis_tlast` in 1: input end of frame
- `s_axis_tready` out 1: input ready
- `coef_addr` out ADDR_W: coefficient index of the current input sample
- `coef_data` in `sample_t_int`: coefficient, combinational function of `coef_addr`
- `m_axis_tdata` out `sample_t_int`: windowed sample
- `m_axis_tvalid` out 1: output valid
- `m_axis_tlast` out 1: output end of frame
- `m_axis_tready` in 1: output ready
- `frame_err` out 1: one-cycle pulse on a framing error
- `frame_cnt` out 16: frames delivered, wraps at 2^16

## Operation
- Advance signal: `adv = ~m_axis_tvalid | m_axis_tready`. It drives the multiplier `en` directly, and shifts the shadow `vld[PIPE_NUM]`/`lst[PIPE_NUM]` pipes.
- Multiplier operands: `a = s_axis_tdata`, `b = coef_data`.
- FSM states:
  - RUN is the reset state.
  - SYNC is entered after a missing-tlast error.
- In RUN:
  - `s_axis_tready = adv`.
  - Accept means `s_axis_tvalid & adv`. On accept, `vld[0] <= 1` and `lst[0] <= s_axis_tlast | (idx == FRAME_LEN-1)`.
  - When `adv` is high without an accept, `vld[0] <= 0`. This inserts a bubble, and the multiplier result for that slot is ignored.
- Index `idx` (= `coef_addr`) increments on accept. It returns to 0 when `idx == FRAME_LEN-1` or when `s_axis_tlast` is accepted.
- Early tlast: `s_axis_tlast` accepted with `idx < FRAME_LEN-1`.
  - `frame_err` pulses.
  - `idx` returns to 0 and the FSM stays in RUN.
  - The sample is still processed and carries `m_axis_tlast`.
- Missing tlast: accept at `idx == FRAME_LEN-1` with `s_axis_tlast = 0`.
  - `frame_err` pulses and the FSM goes to SYNC.
  - The sample is processed with `m_axis_tlast = 1`.
- In SYNC:
  - `s_axis_tready = 1` and `vld[0] <= 0` whenever `adv` is high.
  - Input samples are dropped, with no output.
  - An accepted `s_axis_tlast` (a dropped sample) returns the FSM to RUN with `idx = 0`.
  - `coef_addr` holds 0.
- Outputs:
  - `m_axis_tvalid = vld[PIPE_NUM-1]`, `m_axis_tlast = lst[PIPE_NUM-1]`, `m_axis_tdata = z`.
- `frame_cnt` increments on `m_axis_tvalid & m_axis_tready & m_axis_tlast`.
- Arithmetic and width rules belong entirely to the multiplier. No rounding or saturation is added here.

## Timing
- Reset values:
  - `s_axis_tready` = 1 (combinational, since `vld` is all zero).
  - `m_axis_tvalid`, `m_axis_tlast`, `frame_err` = 0.
  - `m_axis_tdata` = '{0,0}; `coef_addr` = 0; `frame_cnt` = 0; state = RUN.
- Latency: a sample accepted at edge t appears on `m_axis` after edge t+PIPE_NUM-1, provided `adv` stays high.
- Throughput is one sample per cycle at full rate.
- A stall (`m_axis_tvalid & ~m_axis_tready`) freezes every pipeline stage and `idx`. `s_axis_tready` drops in the same cycle. No sample is lost or duplicated.
- `frame_err` is registered and asserts the cycle after the offending accept.
- Reset mid-operation clears in-flight samples, and they are never output.

## Structure
- `sample_t_int` comes from `axis_pkg`.
- The FSM enum `wfunc_ctrl_state_t` (SYNC/RUN) is added to `axis_pkg`.
- One sub-module: `complex_int_mult` with `#(.PIPE_NUM(PIPE_NUM))`, `en` tied to `adv`.
- The shadow valid/last pipes live in this block.

## Test plan
All scenarios use FRAME_LEN=4, PIPE_NUM=3.

1. Reset, then idle:
   - `s_axis_tready` = 1, `m_axis_tvalid` = 0, `coef_addr` = 0, `frame_cnt` = 0.
2. Frame {1,0},{2,0},{3,0},{4,0} back-to-back with coef {2,1}, `m_axis_tready` = 1:
   - Outputs {2,1},{4,2},{6,3},{8,4} on consecutive cycles, starting 3 cycles after the first accept.
   - tlast on the 4th output only; `frame_cnt` = 1.
3. Same frame with `m_axis_tready` low for 5 cycles while the 2nd output is valid:
   - Identical output sequence, no duplicates.
   - `s_axis_tready` low exactly during the stall.
4. tlast on the 2nd sample:
   - `frame_err` pulses once; outputs 2 samples, the 2nd with tlast.
   - The next sample uses `coef_addr` 0.
5. 4 samples without tlast, then 2 samples with tlast on the 2nd, then a normal frame:
   - `frame_err` pulses; 4 outputs with tlast on the 4th.
   - The 2 extra samples are dropped; the next frame is output normally.
   - `frame_cnt` = 2.
6. Assert `rst_n` low with 2 samples in flight:
   - Outputs return to reset values immediately, and neither sample appears after release.
